// File: rtl/ex_stage_if.sv
// E-stage bundle in, M-stage bundle out, plus the fetch redirect and the stall
// request of the RV32 execute stage.
interface ex_stage_if #(parameter int XLEN = 32);
    logic            RegWriteE;
    logic            MemWriteE;
    logic            JumpE;
    logic            BranchE;
    logic            ALUSrcE;
    logic            signE;
    logic            PCTargetSrcE;
    logic [2:0]      ResultSrcE;
    logic [1:0]      Byte_Half_OpE;
    logic [3:0]      ALUControlE;
    logic [2:0]      BranchCondE;
    logic [XLEN-1:0] RD1E;
    logic [XLEN-1:0] RD2E;
    logic [XLEN-1:0] PCE;
    logic [XLEN-1:0] ImmExtE;
    logic [XLEN-1:0] PCPlus4E;
    logic [4:0]      RdE;
    logic [1:0]      ForwardAE;
    logic [1:0]      ForwardBE;
    logic [XLEN-1:0] ResultW;

    logic            PCSrcE;
    logic [XLEN-1:0] PCTargetE;
    logic            StallE;
    logic            RegWriteM;
    logic            MemWriteM;
    logic            signM;
    logic [2:0]      ResultSrcM;
    logic [1:0]      Byte_Half_OpM;
    logic [XLEN-1:0] ALUResultM;
    logic [XLEN-1:0] WriteDataM;
    logic [XLEN-1:0] PCPlus4M;
    logic [XLEN-1:0] PCTargetM;
    logic [XLEN-1:0] ImmExtM;
    logic [4:0]      RdM;

    modport slave (
        input  RegWriteE, MemWriteE, JumpE, BranchE, ALUSrcE, signE, PCTargetSrcE,
               ResultSrcE, Byte_Half_OpE, ALUControlE, BranchCondE,
               RD1E, RD2E, PCE, ImmExtE, PCPlus4E, RdE, ForwardAE, ForwardBE, ResultW,
        output PCSrcE, PCTargetE, StallE, RegWriteM, MemWriteM, signM, ResultSrcM,
               Byte_Half_OpM, ALUResultM, WriteDataM, PCPlus4M, PCTargetM, ImmExtM, RdM
    );

    modport master (
        output RegWriteE, MemWriteE, JumpE, BranchE, ALUSrcE, signE, PCTargetSrcE,
               ResultSrcE, Byte_Half_OpE, ALUControlE, BranchCondE,
               RD1E, RD2E, PCE, ImmExtE, PCPlus4E, RdE, ForwardAE, ForwardBE, ResultW,
        input  PCSrcE, PCTargetE, StallE, RegWriteM, MemWriteM, signM, ResultSrcM,
               Byte_Half_OpM, ALUResultM, WriteDataM, PCPlus4M, PCTargetM, ImmExtM, RdM
    );
endinterface

// File: rtl/ex_stage.sv
// RV32 execute stage: forwarding, ALU, branch resolution, E->M register.
// Define EX_MUL_EN to build the 33-cycle iterative multiplier (MUL/MULH/MULHSU/MULHU).
module ex_stage #(
    parameter int XLEN = 32
) (
    input  logic      CLK,
    input  logic      RST,
    ex_stage_if.slave ex
);
    localparam logic [3:0] OP_ADD    = 4'b0000;
    localparam logic [3:0] OP_SUB    = 4'b0001;
    localparam logic [3:0] OP_AND    = 4'b0010;
    localparam logic [3:0] OP_OR     = 4'b0011;
    localparam logic [3:0] OP_XOR    = 4'b0100;
    localparam logic [3:0] OP_SLT    = 4'b0101;
    localparam logic [3:0] OP_SLTU   = 4'b0110;
    localparam logic [3:0] OP_SLL    = 4'b0111;
    localparam logic [3:0] OP_SRL    = 4'b1000;
    localparam logic [3:0] OP_SRA    = 4'b1001;
    localparam logic [3:0] OP_PASSB  = 4'b1010;
    localparam logic [3:0] OP_MUL    = 4'b1011;
    localparam logic [3:0] OP_MULH   = 4'b1100;
    localparam logic [3:0] OP_MULHSU = 4'b1101;
    localparam logic [3:0] OP_MULHU  = 4'b1110;

    logic [XLEN-1:0] src_a_s;
    logic [XLEN-1:0] write_data_s;
    logic [XLEN-1:0] src_b_s;
    logic [XLEN:0]   alu_sub_s;
    logic [XLEN:0]   cmp_sub_s;
    logic [4:0]      shamt_s;
    logic [XLEN-1:0] alu_core_s;
    logic [XLEN-1:0] alu_result_s;
    logic            lt_s;
    logic            ltu_s;
    logic            eq_s;
    logic            taken_s;
    logic [XLEN-1:0] pc_sum_s;
    logic [XLEN-1:0] jalr_sum_s;
    logic            stall_s;

    logic            reg_write_r;
    logic            mem_write_r;
    logic            sign_r;
    logic [2:0]      result_src_r;
    logic [1:0]      byte_half_op_r;
    logic [XLEN-1:0] alu_result_r;
    logic [XLEN-1:0] write_data_r;
    logic [XLEN-1:0] pc_plus4_r;
    logic [XLEN-1:0] pc_target_r;
    logic [XLEN-1:0] imm_ext_r;
    logic [4:0]      rd_r;

    // Operand forwarding muxes
    always_comb begin
        case (ex.ForwardAE)
            2'b01:   src_a_s = ex.ResultW;
            2'b10:   src_a_s = alu_result_r;
            default: src_a_s = ex.RD1E;
        endcase
        case (ex.ForwardBE)
            2'b01:   write_data_s = ex.ResultW;
            2'b10:   write_data_s = alu_result_r;
            default: write_data_s = ex.RD2E;
        endcase
        if (ex.ALUSrcE) begin
            src_b_s = ex.ImmExtE;
        end else begin
            src_b_s = write_data_s;
        end
    end

    // 33-bit signed differences; the unsigned borrow is the signed sign bit
    // flipped whenever the operands' top bits differ.
    assign alu_sub_s = {src_a_s[XLEN-1], src_a_s} - {src_b_s[XLEN-1], src_b_s};
    assign cmp_sub_s = {src_a_s[XLEN-1], src_a_s} - {write_data_s[XLEN-1], write_data_s};
    assign shamt_s   = src_b_s[4:0];

    // Single-cycle ALU
    always_comb begin
        case (ex.ALUControlE)
            OP_ADD:   alu_core_s = src_a_s + src_b_s;
            OP_SUB:   alu_core_s = alu_sub_s[XLEN-1:0];
            OP_AND:   alu_core_s = src_a_s & src_b_s;
            OP_OR:    alu_core_s = src_a_s | src_b_s;
            OP_XOR:   alu_core_s = src_a_s ^ src_b_s;
            OP_SLT:   alu_core_s = {{(XLEN-1){1'b0}}, alu_sub_s[XLEN]};
            OP_SLTU:  alu_core_s = {{(XLEN-1){1'b0}},
                                    alu_sub_s[XLEN] ^ src_a_s[XLEN-1] ^ src_b_s[XLEN-1]};
            OP_SLL:   alu_core_s = src_a_s << shamt_s;
            OP_SRL:   alu_core_s = src_a_s >> shamt_s;
            OP_SRA:   alu_core_s = $unsigned($signed(src_a_s) >>> shamt_s);
            OP_PASSB: alu_core_s = src_b_s;
            default:  alu_core_s = {XLEN{1'b0}};
        endcase
    end

    assign eq_s  = (cmp_sub_s[XLEN-1:0] == {XLEN{1'b0}});
    assign lt_s  = cmp_sub_s[XLEN];
    assign ltu_s = cmp_sub_s[XLEN] ^ src_a_s[XLEN-1] ^ write_data_s[XLEN-1];

    // Branch condition decode
    always_comb begin
        case (ex.BranchCondE)
            3'b000:  taken_s = eq_s;
            3'b001:  taken_s = ~eq_s;
            3'b100:  taken_s = lt_s;
            3'b101:  taken_s = ~lt_s;
            3'b110:  taken_s = ltu_s;
            3'b111:  taken_s = ~ltu_s;
            default: taken_s = 1'b0;
        endcase
    end

    assign pc_sum_s     = ex.PCE + ex.ImmExtE;
    assign jalr_sum_s   = src_a_s + ex.ImmExtE;
    assign ex.PCTargetE = ex.PCTargetSrcE ? (jalr_sum_s & ~{{(XLEN-1){1'b0}}, 1'b1}) : pc_sum_s;
    assign ex.PCSrcE    = (ex.JumpE | (ex.BranchE & taken_s)) & ~stall_s;

`ifdef EX_MUL_EN
    typedef enum logic [1:0] {
        MUL_IDLE = 2'd0,
        MUL_RUN  = 2'd1,
        MUL_DONE = 2'd2
    } mul_state_t;

    mul_state_t        state_r;
    mul_state_t        state_next_s;
    logic              is_mul_s;
    logic              op_signed_a_s;
    logic              op_signed_b_s;
    logic              fsm_stall_s;
    logic [2*XLEN-1:0] mcand_r;
    logic [XLEN-1:0]   mplier_r;
    logic [2*XLEN-1:0] acc_r;
    logic [4:0]        cnt_r;
    logic              neg_r;
    logic [3:0]        op_r;
    logic [2*XLEN-1:0] product_s;
    logic [XLEN-1:0]   mul_result_s;

    function automatic logic [XLEN-1:0] magnitude(input logic [XLEN-1:0] v, input logic is_signed);
        if (is_signed && v[XLEN-1]) begin
            return ~v + {{(XLEN-1){1'b0}}, 1'b1};
        end else begin
            return v;
        end
    endfunction

    assign is_mul_s      = (ex.ALUControlE == OP_MUL)  || (ex.ALUControlE == OP_MULH) ||
                           (ex.ALUControlE == OP_MULHSU) || (ex.ALUControlE == OP_MULHU);
    assign op_signed_a_s = (ex.ALUControlE == OP_MULH) || (ex.ALUControlE == OP_MULHSU);
    assign op_signed_b_s = (ex.ALUControlE == OP_MULH);

    // Multiplier state register
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state_r <= MUL_IDLE;
        end else begin
            state_r <= state_next_s;
        end
    end

    // Multiplier next-state logic
    always_comb begin
        state_next_s = state_r;
        case (state_r)
            MUL_IDLE: begin
                if (is_mul_s) begin
                    state_next_s = MUL_RUN;
                end else begin
                    state_next_s = MUL_IDLE;
                end
            end
            MUL_RUN: begin
                if (cnt_r == 5'd31) begin
                    state_next_s = MUL_DONE;
                end else begin
                    state_next_s = MUL_RUN;
                end
            end
            MUL_DONE: state_next_s = MUL_IDLE;
            default:  state_next_s = MUL_IDLE;
        endcase
    end

    // Multiplier outputs: stall request and sign-corrected result
    always_comb begin
        fsm_stall_s = ((state_r == MUL_IDLE) && is_mul_s) || (state_r == MUL_RUN);
        if (neg_r) begin
            product_s = ~acc_r + {{(2*XLEN-1){1'b0}}, 1'b1};
        end else begin
            product_s = acc_r;
        end
        if (op_r == OP_MUL) begin
            mul_result_s = product_s[XLEN-1:0];
        end else begin
            mul_result_s = product_s[2*XLEN-1:XLEN];
        end
    end

    // Shift-add datapath: operands captured only when leaving IDLE
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            mcand_r  <= {(2*XLEN){1'b0}};
            mplier_r <= {XLEN{1'b0}};
            acc_r    <= {(2*XLEN){1'b0}};
            cnt_r    <= 5'd0;
            neg_r    <= 1'b0;
            op_r     <= 4'd0;
        end else begin
            case (state_r)
                MUL_IDLE: begin
                    if (is_mul_s) begin
                        mcand_r  <= {{XLEN{1'b0}}, magnitude(src_a_s, op_signed_a_s)};
                        mplier_r <= magnitude(src_b_s, op_signed_b_s);
                        acc_r    <= {(2*XLEN){1'b0}};
                        cnt_r    <= 5'd0;
                        neg_r    <= (op_signed_a_s & src_a_s[XLEN-1]) ^ (op_signed_b_s & src_b_s[XLEN-1]);
                        op_r     <= ex.ALUControlE;
                    end else begin
                        cnt_r <= cnt_r;
                    end
                end
                MUL_RUN: begin
                    if (mplier_r[0]) begin
                        acc_r <= acc_r + mcand_r;
                    end else begin
                        acc_r <= acc_r;
                    end
                    mcand_r  <= mcand_r << 1;
                    mplier_r <= mplier_r >> 1;
                    cnt_r    <= cnt_r + 5'd1;
                end
                default: cnt_r <= cnt_r;
            endcase
        end
    end

    assign stall_s      = fsm_stall_s & ~RST;
    assign alu_result_s = (state_r == MUL_DONE) ? mul_result_s : alu_core_s;
`else
    assign stall_s      = 1'b0;
    assign alu_result_s = alu_core_s;
`endif

    assign ex.StallE = stall_s;

    // E->M pipeline register; a stall loads an all-zero bubble
    always_ff @(posedge CLK or posedge RST) begin
        if (RST || stall_s) begin
            reg_write_r    <= 1'b0;
            mem_write_r    <= 1'b0;
            sign_r         <= 1'b0;
            result_src_r   <= 3'd0;
            byte_half_op_r <= 2'd0;
            alu_result_r   <= {XLEN{1'b0}};
            write_data_r   <= {XLEN{1'b0}};
            pc_plus4_r     <= {XLEN{1'b0}};
            pc_target_r    <= {XLEN{1'b0}};
            imm_ext_r      <= {XLEN{1'b0}};
            rd_r           <= 5'd0;
        end else begin
            reg_write_r    <= ex.RegWriteE;
            mem_write_r    <= ex.MemWriteE;
            sign_r         <= ex.signE;
            result_src_r   <= ex.ResultSrcE;
            byte_half_op_r <= ex.Byte_Half_OpE;
            alu_result_r   <= alu_result_s;
            write_data_r   <= write_data_s;
            pc_plus4_r     <= ex.PCPlus4E;
            pc_target_r    <= ex.PCTargetE;
            imm_ext_r      <= ex.ImmExtE;
            rd_r           <= ex.RdE;
        end
    end

    assign ex.RegWriteM     = reg_write_r;
    assign ex.MemWriteM     = mem_write_r;
    assign ex.signM         = sign_r;
    assign ex.ResultSrcM    = result_src_r;
    assign ex.Byte_Half_OpM = byte_half_op_r;
    assign ex.ALUResultM    = alu_result_r;
    assign ex.WriteDataM    = write_data_r;
    assign ex.PCPlus4M      = pc_plus4_r;
    assign ex.PCTargetM     = pc_target_r;
    assign ex.ImmExtM       = imm_ext_r;
    assign ex.RdM           = rd_r;
endmodule

// File: tb/tb_ex_stage.sv
// Scoreboard bench for ex_stage: stimulus pushes expected M-stage results,
// a negedge monitor pops and compares whenever RegWriteM is high.
module tb_ex_stage;
    logic CLK = 1'b0;
    logic RST;

    ex_stage_if #(.XLEN(32)) bus ();
    ex_stage #(.XLEN(32)) dut (.CLK(CLK), .RST(RST), .ex(bus.slave));

    always #5 CLK = ~CLK;

    typedef struct {
        logic [31:0] alu;
        logic [31:0] tgt;
        logic [4:0]  rd;
    } exp_t;

    exp_t sb_q[$];
    exp_t mon_e;
    int   checks = 0;
    int   errors = 0;
    logic [4:0] rd_seq = 5'd1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    always @(negedge CLK) begin
        if (!RST && bus.RegWriteM === 1'b1) begin
            if (sb_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_result: got %h with empty scoreboard", bus.ALUResultM);
            end else begin
                mon_e = sb_q.pop_front();
                check("alu_result_m", bus.ALUResultM, mon_e.alu);
                check("pc_target_m", bus.PCTargetM, mon_e.tgt);
                check("rd_m", {27'd0, bus.RdM}, {27'd0, mon_e.rd});
            end
        end
    end

    task automatic drive(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b,
                         input logic [31:0] imm, input logic alusrc);
        bus.RegWriteE = 1'b1;     bus.MemWriteE = 1'b0;    bus.JumpE = 1'b0;
        bus.BranchE = 1'b0;       bus.ALUSrcE = alusrc;    bus.signE = 1'b0;
        bus.PCTargetSrcE = 1'b0;  bus.ResultSrcE = 3'd0;   bus.Byte_Half_OpE = 2'd0;
        bus.ALUControlE = op;     bus.BranchCondE = 3'b010;
        bus.RD1E = a;             bus.RD2E = b;            bus.PCE = 32'h0000_0100;
        bus.ImmExtE = imm;        bus.PCPlus4E = 32'h0000_0104;
        bus.RdE = rd_seq;         rd_seq = rd_seq + 5'd1;
        bus.ForwardAE = 2'b00;    bus.ForwardBE = 2'b00;   bus.ResultW = 32'd0;
    endtask

    // Holds the bundle while StallE is high, then lets it advance.
    task automatic finish_issue(input logic [31:0] exp_alu, input logic [31:0] exp_tgt, output int stalls);
        exp_t e;
        e.alu = exp_alu;
        e.tgt = exp_tgt;
        e.rd  = bus.RdE;
        sb_q.push_back(e);
        stalls = 0;
        @(negedge CLK);
        while (bus.StallE === 1'b1 && stalls < 100) begin
            stalls++;
            if (stalls == 2) check("bubble_regwrite_m", {31'd0, bus.RegWriteM}, 32'd0);
            @(negedge CLK);
        end
        @(posedge CLK);
        #1;
        bus.RegWriteE = 1'b0;
    endtask

    task automatic alu_op(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b,
                          input logic [31:0] imm, input logic alusrc, input logic [31:0] exp);
        int st;
        drive(op, a, b, imm, alusrc);
        finish_issue(exp, 32'h0000_0100 + imm, st);
    endtask

    task automatic mul_op(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b,
                          input logic [31:0] exp);
        int st;
        drive(op, a, b, 32'd0, 1'b0);
        bus.JumpE = 1'b1;
        #3;
`ifdef EX_MUL_EN
        check("mul_stall_e", {31'd0, bus.StallE}, 32'd1);
        check("mul_pcsrc_suppressed", {31'd0, bus.PCSrcE}, 32'd0);
        finish_issue(exp, 32'h0000_0100, st);
        check("mul_stall_cycles", st, 33);
`else
        check("mul_stall_e", {31'd0, bus.StallE}, 32'd0);
        check("mul_pcsrc", {31'd0, bus.PCSrcE}, 32'd1);
        finish_issue(32'd0, 32'h0000_0100, st);
        check("mul_stall_cycles", st, 0);
`endif
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        int st;
        logic [7:0] taken_tbl;
        RST = 1'b1;
        drive(4'd0, 32'd0, 32'd0, 32'd0, 1'b0);
        bus.RegWriteE = 1'b0;
        repeat (2) @(posedge CLK);
        #1;
        check("reset_regwrite_m", {31'd0, bus.RegWriteM}, 32'd0);
        check("reset_alu_result_m", bus.ALUResultM, 32'd0);
        check("reset_rd_m", {27'd0, bus.RdM}, 32'd0);
        check("reset_stall_e", {31'd0, bus.StallE}, 32'd0);
        @(posedge CLK);
        #1;
        RST = 1'b0;

        alu_op(4'b0000, 32'hFFFF_FFF0, 32'd0, 32'h10, 1'b1, 32'h0000_0000);
        alu_op(4'b1001, 32'hFFFF_FFF0, 32'd0, 32'h4,  1'b1, 32'hFFFF_FFFF);
        alu_op(4'b0000, 32'hFFFF_FFFF, 32'd2, 32'd0,  1'b0, 32'h0000_0001);
        alu_op(4'b0001, 32'd5,         32'd7, 32'd0,  1'b0, 32'hFFFF_FFFE);
        alu_op(4'b0101, 32'hFFFF_FFFF, 32'd1, 32'd0,  1'b0, 32'h0000_0001);
        alu_op(4'b0110, 32'hFFFF_FFFF, 32'd1, 32'd0,  1'b0, 32'h0000_0000);
        alu_op(4'b0110, 32'd1, 32'hFFFF_FFFF, 32'd0,  1'b0, 32'h0000_0001);
        alu_op(4'b0111, 32'h1234,      32'd0, 32'd0,  1'b0, 32'h0000_1234);
        alu_op(4'b0111, 32'd1,       32'h3F,  32'd0,  1'b0, 32'h8000_0000);
        alu_op(4'b1000, 32'h8000_0000, 32'h1F, 32'd0, 1'b0, 32'h0000_0001);
        alu_op(4'b0010, 32'hF0F0,   32'hFF00, 32'd0,  1'b0, 32'h0000_F000);
        alu_op(4'b0011, 32'hF0F0,   32'hFF00, 32'd0,  1'b0, 32'h0000_FFF0);
        alu_op(4'b0100, 32'hF0F0,   32'hFF00, 32'd0,  1'b0, 32'h0000_0FF0);
        alu_op(4'b1010, 32'h123,       32'd0, 32'h77, 1'b1, 32'h0000_0077);
        alu_op(4'b1111, 32'd5,         32'd6, 32'd0,  1'b0, 32'h0000_0000);

        // Forwarding from M (previous result) and W
        alu_op(4'b0000, 32'h55, 32'd0, 32'd0, 1'b1, 32'h55);
        drive(4'b0000, 32'd0, 32'd0, 32'd0, 1'b0);
        bus.ForwardAE = 2'b10; bus.ForwardBE = 2'b01; bus.ResultW = 32'h22;
        finish_issue(32'h77, 32'h100, st);
        drive(4'b0000, 32'd9, 32'd1, 32'd0, 1'b0);
        bus.ForwardAE = 2'b11; bus.ForwardBE = 2'b11; bus.ResultW = 32'h1000;
        finish_issue(32'hA, 32'h100, st);

        // Every branch condition with SrcA=-1, WriteDataE=1
        taken_tbl = 8'b1001_0010;
        for (int i = 0; i < 8; i++) begin
            drive(4'b0000, 32'hFFFF_FFFF, 32'd1, 32'h40, 1'b0);
            bus.PCE = 32'h200; bus.BranchE = 1'b1; bus.BranchCondE = i[2:0];
            #3;
            check("branch_pcsrc", {31'd0, bus.PCSrcE}, {31'd0, taken_tbl[i]});
            check("branch_target", bus.PCTargetE, 32'h240);
            finish_issue(32'd0, 32'h240, st);
        end
        drive(4'b0000, 32'd7, 32'd7, 32'h8, 1'b0);
        bus.BranchE = 1'b1; bus.BranchCondE = 3'b000;
        #3;
        check("beq_equal_pcsrc", {31'd0, bus.PCSrcE}, 32'd1);
        finish_issue(32'hE, 32'h108, st);
        drive(4'b0000, 32'hFFFF_FFFF, 32'd1, 32'h8, 1'b0);
        bus.BranchCondE = 3'b100;
        #3;
        check("no_branch_pcsrc", {31'd0, bus.PCSrcE}, 32'd0);
        finish_issue(32'd0, 32'h108, st);

        // JALR target clears bit 0
        drive(4'b0000, 32'h1003, 32'd0, 32'd0, 1'b1);
        bus.PCTargetSrcE = 1'b1; bus.JumpE = 1'b1;
        #3;
        check("jalr_target", bus.PCTargetE, 32'h1002);
        check("jalr_pcsrc", {31'd0, bus.PCSrcE}, 32'd1);
        finish_issue(32'h1003, 32'h1002, st);

        mul_op(4'b1100, 32'hFFFF_FFFD, 32'd7, 32'hFFFF_FFFF);
        mul_op(4'b1011, 32'hFFFF_FFFD, 32'd7, 32'hFFFF_FFEB);
        mul_op(4'b1110, 32'hFFFF_FFFF, 32'd2, 32'h0000_0001);
        mul_op(4'b1101, 32'hFFFF_FFFF, 32'd2, 32'hFFFF_FFFF);
        mul_op(4'b1101, 32'd2, 32'hFFFF_FFFF, 32'h0000_0001);
        mul_op(4'b1100, 32'h8000_0000, 32'h8000_0000, 32'h4000_0000);

        // Asynchronous reset clears a freshly loaded M stage
        drive(4'b0000, 32'h99, 32'd0, 32'd0, 1'b1);
        @(posedge CLK);
        #2;
        RST = 1'b1;
        #1;
        check("async_reset_regwrite_m", {31'd0, bus.RegWriteM}, 32'd0);
        check("async_reset_alu_result_m", bus.ALUResultM, 32'd0);
        check("async_reset_rd_m", {27'd0, bus.RdM}, 32'd0);
        bus.RegWriteE = 1'b0;
        @(posedge CLK);
        #1;
        RST = 1'b0;

`ifdef EX_MUL_EN
        // Reset in the middle of a multiply
        drive(4'b1011, 32'd3, 32'd5, 32'd0, 1'b0);
        repeat (11) @(negedge CLK);
        check("mid_run_stall_e", {31'd0, bus.StallE}, 32'd1);
        #1;
        RST = 1'b1;
        #1;
        check("mid_run_reset_stall_e", {31'd0, bus.StallE}, 32'd0);
        check("mid_run_reset_regwrite_m", {31'd0, bus.RegWriteM}, 32'd0);
        check("mid_run_reset_alu_result_m", bus.ALUResultM, 32'd0);
        bus.ALUControlE = 4'b0000;
        bus.RegWriteE = 1'b0;
        @(posedge CLK);
        #1;
        RST = 1'b0;
`endif
        drive(4'b0000, 32'h30, 32'd0, 32'h4, 1'b1);
        finish_issue(32'h34, 32'h104, st);
        check("post_reset_stall_cycles", st, 0);

        repeat (3) @(posedge CLK);
        check("scoreboard_empty", sb_q.size(), 0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/ex_stage.md
# ex_stage

Execute stage of the 5-stage RV32 pipeline. Consumes the E-stage bundle from the decode→execute register, resolves operand forwarding, computes ALU/branch/jump results and the branch target, runs an optional iterative multiplier, and registers results into the execute→memory pipeline register. It drives `PCSrcE`/`PCTargetE` to fetch and `StallE` to the hazard unit.

## Interface
Parameters:
- XLEN, 32, datapath width. Only 32 is supported.

Ports (name, direction, width, meaning):
- CLK, in, 1, clock.
- RST, in, 1, reset, asynchronous, active-high.
- RegWriteE MemWriteE JumpE BranchE ALUSrcE signE PCTargetSrcE, in, 1 each, E-stage controls.
- ResultSrcE, in, 3, result select, passed to M.
- Byte_Half_OpE, in, 2, load/store size, passed to M.
- ALUControlE, in, 4, ALU operation.
- BranchCondE, in, 3, branch funct3.
- RD1E RD2E PCE ImmExtE PCPlus4E, in, 32 each, E-stage data.
- RdE, in, 5, destination register.
- ForwardAE ForwardBE, in, 2 each, operand select: 00 = RD1E/RD2E, 01 = ResultW, 10 = ALUResultM, 11 = RD1E/RD2E.
- ResultW, in, 32, writeback result.
- PCSrcE, out, 1, redirect fetch.
- PCTargetE, out, 32, redirect address.
- StallE, out, 1, multiplier busy. The hazard unit holds F, D and D2E while this is high.
- RegWriteM MemWriteM signM, out, 1 each.
- ResultSrcM, out, 3.
- Byte_Half_OpM, out, 2.
- ALUResultM WriteDataM PCPlus4M PCTargetM ImmExtM, out, 32 each.
- RdM, out, 5.

## Operation
- Operands:
  - SrcA = fwd(ForwardAE).
  - WriteDataE = fwd(ForwardBE).
  - SrcB = ALUSrcE ? ImmExtE : WriteDataE.
- ALUControlE encodings:
  - 0000 ADD, 0001 SUB, 0010 AND, 0011 OR, 0100 XOR.
  - 0101 SLT (signed), 0110 SLTU.
  - 0111 SLL, 1000 SRL, 1001 SRA. All shifts use SrcB[4:0].
  - 1010 pass SrcB.
  - 1011 MUL (low 32 bits).
  - 1100 MULH (s×s, high), 1101 MULHSU (s×u, high), 1110 MULHU (u×u, high).
  - 1111 result 0.
- Branch taken, per BranchCondE:
  - 000 EQ, 001 NE.
  - 100 LT, 101 GE (signed).
  - 110 LTU, 111 GEU.
  - 010 and 011 are never taken.
  - The compare is on SrcA vs WriteDataE.
- PCTargetE:
  - PCTargetSrcE=0: PCE+ImmExtE.
  - PCTargetSrcE=1: (SrcA+ImmExtE) with bit 0 cleared.
- PCSrcE = JumpE | (BranchE & taken). This is combinational.
- PCSrcE is forced to 0 while StallE=1.
- Multiplier FSM (IDLE, RUN, DONE):
  - IDLE→RUN when ALUControlE is one of 1011–1110.
    - On that transition, capture magnitudes of SrcA/SrcB, the signed-ness of each operand, and the op.
    - Clear the 64-bit accumulator and set the count to 0.
  - RUN: radix-2 shift-add, one multiplier bit per cycle. After 32 iterations, go to DONE.
  - DONE: apply the sign correction (two's-complement negate when signs differ). Present low or high 32 bits as the ALU result. Return to IDLE.
  - StallE = 1 in IDLE when a mul op is present, and in RUN. StallE = 0 in DONE.
  - The FSM ignores ALUControlE in RUN and DONE. A mul op still present in IDLE right after DONE would restart it; the hazard unit advances D2E on the DONE cycle, which prevents this.
- E→M register:
  - Load on every CLK edge.
  - While StallE=1, load a bubble: RegWriteM=0, MemWriteM=0, ResultSrcM=0, RdM=0. The data fields hold don't-care values, driven as 0.
- Reset: all M outputs, FSM=IDLE, accumulator and count cleared to 0. Reset during RUN aborts the multiply.

## Timing
- Non-mul ops: result in ALUResultM one cycle after the op is in E.
- Mul op entering E at cycle t:
  - StallE is high for cycles t..t+32 (33 cycles).
  - DONE at t+33.
  - Product visible on ALUResultM at t+34.
- Forwarded values are sampled only at FSM capture. Later changes to ResultW or ALUResultM do not affect the product.
- SUB and compares use 33-bit arithmetic for the sign and carry. All arithmetic wraps at 32 bits.
- Shift amount 0 passes SrcA unchanged.

## Configuration
- EX_MUL_EN defined: the multiplier FSM is present, as described above.
- EX_MUL_EN undefined:
  - Encodings 1011–1110 return 0 with single-cycle latency.
  - StallE is tied to 0 and no FSM logic is generated.

## Test plan
- ADD/SUB/SRA: SrcA=0xFFFF_FFF0 and ImmExtE=0x10 with ALUSrcE=1 and ADD → ALUResultM=0x0. Repeat with SRA and SrcB=4 → 0xFFFF_FFFF.
- Forwarding: ForwardAE=10 with ALUResultM=0x55, and ForwardBE=01 with ResultW=0x22, op ADD → 0x77.
- Branch: BLT (BranchCondE=100) with BranchE=1, SrcA=-1, WriteDataE=1 → PCSrcE=1 and PCTargetE=PCE+ImmExtE. Same values with BLTU (110) → PCSrcE=0.
- JALR: PCTargetSrcE=1 with SrcA=0x1003 and ImmExtE=0 → PCTargetE=0x1002.
- MULH: -3 × 7 → StallE=1 for 33 cycles, then ALUResultM=0xFFFF_FFFF. MUL gives 0xFFFF_FFEB. MULHU 0xFFFF_FFFF×2 gives 0x1. Bubbles appear in M during the stall.
- Reset mid-RUN at cycle t+10: M outputs go to 0 asynchronously, StallE=0, and the FSM is in IDLE on release.
